// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Multi-cycle AES MixColumns / InvMixColumns engine on a full 128-bit state.
//   A state is accepted in IDLE, transformed COLS_PER_CYC columns per cycle
//   in CALC, and presented in HOLD until the consumer takes it. The direction
//   (forward/inverse) is latched with each block, so encrypt and decrypt
//   rounds can share this datapath.
//
// Parameters
//   COLS_PER_CYC : columns transformed per cycle (1, 2 or 4)
//   OUT_REG      : 1 = result registered into a dedicated output register
//                  (+1 cycle), 0 = out_state driven from the working register
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input state presented
//   in_ready   out  engine can accept a state (IDLE only)
//   in_state   in   128-bit state, column c = bits [127-32c -: 32],
//                   row 0 byte is the MSB of each column
//   in_inv     in   0 = MixColumns, 1 = InvMixColumns (sampled with in_state)
//   out_valid  out  result available
//   out_ready  in   consumer accepts result
//   out_state  out  transformed state, same layout as in_state
//   busy       out  high from accept until the result handshake completes

module mix_columns_seq #(
  parameter int COLS_PER_CYC = 1,
  parameter int OUT_REG      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYC must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYC);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYC);
  localparam logic       USE_OREG = (OUT_REG != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_col;
  logic                 r_inv;
  logic                 r_done;
  // Packed column view: column c lives at index 3-c, matching bits [127-32c -: 32].
  logic [3:0][31:0]     r_work;
  logic [3:0][31:0]     w_work_nxt;
  logic                 w_accept;
  logic                 w_calc_en;
  logic                 w_load_out;
  logic                 w_last_grp;

  // GF(2^8) multiply by x, reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column. The inverse is a cheap precondition (multiply by 04 folded
  // onto the opposite rows) followed by the forward transform; together they
  // equal the 0e/0b/0d/09 matrix.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3, u, v, t;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    u  = xtime(xtime(a0 ^ a2));
    v  = xtime(xtime(a1 ^ a3));
    if (inv) begin
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1),
            a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3),
            a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  assign w_last_grp = (r_col == LAST_COL);

  // Transform the current column group in place; other columns pass through.
  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < COLS_PER_CYC; k++) begin
      w_work_nxt[2'd3 - (r_col + 2'(k))] = mix_col(r_work[2'd3 - (r_col + 2'(k))], r_inv);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_calc_en   = 1'b0;
    w_load_out  = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        // r_done marks the extra cycle that copies the finished state into
        // the output register; it only ever sets when OUT_REG is enabled.
        if (r_done) begin
          w_load_out  = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_calc_en = 1'b1;
          if (w_last_grp && !USE_OREG) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col  <= 2'd0;
      r_inv  <= 1'b0;
      r_done <= 1'b0;
      r_work <= '0;
    end else if (w_accept) begin
      r_col  <= 2'd0;
      r_inv  <= in_inv;
      r_done <= 1'b0;
      r_work <= in_state;
    end else if (w_calc_en) begin
      r_work <= w_work_nxt;
      // The counter stops on the last group; leaving CALC ends the block.
      if (w_last_grp) begin
        r_done <= USE_OREG;
      end else begin
        r_col <= r_col + COL_STEP;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [127:0] r_out;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_out <= '0;
      end else if (w_load_out) begin
        r_out <= r_work;
      end
    end
    assign out_state = r_out;
  end else begin : g_no_oreg
    assign out_state = r_work;
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq
//   Directed bench for mix_columns_seq. Three instances share clk/rst_n:
//   index 0 = COLS_PER_CYC 1, index 1 = COLS_PER_CYC 4, index 2 =
//   COLS_PER_CYC 2, all with OUT_REG 1. Expected values are hand-computed
//   constants or come from a GF(2^8) matrix model.

module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(
      .COLS_PER_CYC((g == 0) ? 1 : ((g == 1) ? 4 : 2)),
      .OUT_REG     (1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Full matrix model: row r uses coefficients rotated right by r.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   b;
    logic [127:0] o;
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 32*c - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(cf[(k - r + 4) % 4], a[k]);
        o[127 - 32*c - 8*r -: 8] = b;
      end
    end
    return o;
  endfunction

  // Present one block on instance d, wait (bounded) for the result, take it.
  // lat counts edges from the accept edge until out_valid is seen high.
  task automatic run_block(input int d, input logic [127:0] st, input logic inv,
                           output logic [127:0] res, output int lat);
    chk("in_ready before accept", {127'd0, in_ready[d]}, 128'd1);
    in_valid[d] = 1'b1;
    in_state[d] = st;
    in_inv[d]   = inv;
    tick();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 50) begin
      tick();
      lat++;
    end
    res = out_state[d];
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V_FIX   = 128'hc6c6c6c6_d4d4d4d5_01010101_c6c6c6c6;
  localparam logic [127:0] V_FIXO  = 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6;

  initial begin
    logic [127:0] res;
    logic [127:0] exp_q [$];
    int           lat;
    int           n_acc;
    int           n_res;
    int           cyc;
    int           last_hs;
    int           bad_gap;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      in_inv[d]    = 1'b0;
      out_ready[d] = 1'b0;
    end
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state on every instance
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset in_ready[%0d]", d), {127'd0, in_ready[d]}, 128'd1);
      chk($sformatf("reset out_valid[%0d]", d), {127'd0, out_valid[d]}, 128'd0);
      chk($sformatf("reset busy[%0d]", d), {127'd0, busy[d]}, 128'd0);
      chk($sformatf("reset out_state[%0d]", d), out_state[d], 128'd0);
    end

    // Forward, one column per cycle
    run_block(0, V_PLAIN, 1'b0, res, lat);
    chk("fwd c1 result", res, V_MIXED);
    chk("fwd c1 latency", 128'(lat), 128'd5);

    // Inverse round trip, four columns per cycle
    run_block(1, V_MIXED, 1'b1, res, lat);
    chk("inv c4 result", res, V_PLAIN);
    chk("inv c4 latency", 128'(lat), 128'd2);

    // Fixed-point columns and xtime reduction, two columns per cycle
    run_block(2, V_FIX, 1'b0, res, lat);
    chk("fix c2 result", res, V_FIXO);
    chk("fix c2 latency", 128'(lat), 128'd3);

    // Backpressure, with in_inv toggling after the accept edge
    in_valid[0] = 1'b1;
    in_state[0] = V_PLAIN;
    in_inv[0]   = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin
      in_inv[0] = ~in_inv[0];
      tick();
      lat++;
    end
    chk("bp result", out_state[0], V_MIXED);
    for (int i = 0; i < 10; i++) begin
      in_inv[0] = ~in_inv[0];
      tick();
      chk($sformatf("bp hold out_valid %0d", i), {127'd0, out_valid[0]}, 128'd1);
      chk($sformatf("bp hold out_state %0d", i), out_state[0], V_MIXED);
      chk($sformatf("bp hold in_ready %0d", i), {127'd0, in_ready[0]}, 128'd0);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("bp release out_valid", {127'd0, out_valid[0]}, 128'd0);
    chk("bp release in_ready", {127'd0, in_ready[0]}, 128'd1);
    chk("bp release busy", {127'd0, busy[0]}, 128'd0);
    chk("bp out_state kept", out_state[0], V_MIXED);

    // Reset during the second CALC cycle
    in_valid[0] = 1'b1;
    in_state[0] = V_FIX;
    in_inv[0]   = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    tick();
    chk("mid busy before reset", {127'd0, busy[0]}, 128'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid reset out_valid", {127'd0, out_valid[0]}, 128'd0);
    chk("mid reset busy", {127'd0, busy[0]}, 128'd0);
    chk("mid reset in_ready", {127'd0, in_ready[0]}, 128'd1);
    chk("mid reset out_state", out_state[0], 128'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    chk("mid no stray out_valid", {127'd0, out_valid[0]}, 128'd0);
    run_block(0, V_FIX, 1'b0, res, lat);
    chk("post reset result", res, V_FIXO);
    chk("post reset latency", 128'(lat), 128'd5);

    // Back-to-back on the two-column instance, alternating direction.
    // Handshakes are spaced by 3 compute edges, one HOLD cycle and one
    // IDLE cycle.
    in_valid[2]  = 1'b1;
    out_ready[2] = 1'b1;
    n_acc   = 0;
    n_res   = 0;
    cyc     = 0;
    last_hs = -1;
    bad_gap = 0;
    while (n_res < 1000 && cyc < 20000) begin
      if (in_valid[2] && in_ready[2]) begin
        in_state[2] = {$urandom, $urandom, $urandom, $urandom};
        in_inv[2]   = n_acc[0];
        exp_q.push_back(ref_mix(in_state[2], in_inv[2]));
        n_acc++;
      end
      if (out_valid[2]) begin
        if (exp_q.size() == 0) begin
          chk("b2b unexpected result", out_state[2], 128'd0);
        end else begin
          chk($sformatf("b2b result %0d", n_res), out_state[2], exp_q.pop_front());
        end
        if (last_hs >= 0 && cyc - last_hs != 5) bad_gap++;
        last_hs = cyc;
        n_res++;
      end
      tick();
      if (n_acc >= 1000) in_valid[2] = 1'b0;
      cyc++;
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b0;
    chk("b2b result count", 128'(n_res), 128'd1000);
    chk("b2b spacing violations", 128'(bad_gap), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
